// File: rtl/fetch_decode_ctrl.sv
// Purpose : fetch PC sequencing, single-outstanding imem requests, IF/ID register with 1-entry skid.
// Latency : grant at t, rvalid at t+1 -> decode valid after the edge ending t+1; redirect flushes next cycle.
// Backpres: stall_d_i holds decode; an in-flight response parks in the skid, no new request until it drains.
//
// Optional feature macro: FD_CTRL_PERF_EN (adds perf_stall_o / perf_bubble_o saturating counters).
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_o/addr_o               fetch request and address (address = fetch PC)
//   imem_gnt_i                      request accepted this cycle
//   imem_rvalid_i/rdata_i           instruction response
//   stall_d_i                       hold decode register
//   redirect_i/redirect_pc_i        taken branch/jump: flush and refetch from target
//   instr_d_o/pc_d_o/pc_plus4_d_o   decode register contents
//   valid_d_o                       decode register holds a real instruction
module fetch_decode_ctrl #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_d_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [31:0]     instr_d_o,
    output logic [XLEN-1:0] pc_d_o,
    output logic [XLEN-1:0] pc_plus4_d_o,
    output logic            valid_d_o
`ifdef FD_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_stall_o,
    output logic [31:0]     perf_bubble_o
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] r_pc_pend;
    logic            r_skid_vld;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;

    logic            w_req;
    logic            w_fire;
    logic            w_rsp;

    // A response only counts in WAIT; in DISCARD (or after a reset) it is stale.
    assign w_rsp  = (r_state == S_WAIT) && imem_rvalid_i;
    assign w_fire = w_req && imem_gnt_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            // A redirect in REQ just retargets pc_f; the request is gated that cycle so no fire.
            S_REQ: begin
                if (w_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    // Response already here gets dropped; otherwise it is still in flight.
                    w_state_nxt = imem_rvalid_i ? S_REQ : S_DISCARD;
                end else if (imem_rvalid_i) begin
                    w_state_nxt = w_fire ? S_WAIT : S_REQ;
                end
            end
            // Further redirects here only move pc_f; the stale response still has to be eaten.
            S_DISCARD: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Back-to-back issue is allowed only as the previous response lands. Holding off while the
    // skid is full, or while a stalled response is heading into it, keeps the skid at one entry.
    always_comb begin
        w_req = 1'b0;
        if ((r_state == S_REQ) || ((r_state == S_WAIT) && imem_rvalid_i)) begin
            w_req = !redirect_i && !r_skid_vld && !(stall_d_i && imem_rvalid_i);
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc_f;

    // ---------------- fetch PC ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_f    <= RESET_PC;
            r_pc_pend <= '0;
        end else begin
            if (redirect_i) begin
                r_pc_f <= redirect_pc_i;
            end else if (w_fire) begin
                r_pc_f <= r_pc_f + PC_STEP;
            end
            if (w_fire) begin
                r_pc_pend <= r_pc_f;
            end
        end
    end

    // ---------------- decode register and skid ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_skid_vld   <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (redirect_i) begin
            r_skid_vld <= 1'b0;
            r_valid_d  <= 1'b0;
        end else if (stall_d_i) begin
            if (w_rsp) begin
                r_skid_vld   <= 1'b1;
                r_skid_instr <= imem_rdata_i;
                r_skid_pc    <= r_pc_pend;
            end
        end else if (r_skid_vld) begin
            r_skid_vld   <= 1'b0;
            r_instr_d    <= r_skid_instr;
            r_pc_d       <= r_skid_pc;
            r_pc_plus4_d <= r_skid_pc + PC_STEP;
            r_valid_d    <= 1'b1;
        end else if (w_rsp) begin
            r_instr_d    <= imem_rdata_i;
            r_pc_d       <= r_pc_pend;
            r_pc_plus4_d <= r_pc_pend + PC_STEP;
            r_valid_d    <= 1'b1;
        end else begin
            r_valid_d <= 1'b0;
        end
    end

    assign instr_d_o    = r_instr_d;
    assign pc_d_o       = r_pc_d;
    assign pc_plus4_d_o = r_pc_plus4_d;
    assign valid_d_o    = r_valid_d;

`ifdef FD_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;
    logic        w_bubble;

    // Mirrors the last arm of the decode-load priority chain.
    assign w_bubble = !redirect_i && !stall_d_i && !r_skid_vld && !w_rsp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (stall_d_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_bubble && (r_perf_bubble != 32'hFFFF_FFFF)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_stall_o  = r_perf_stall;
    assign perf_bubble_o = r_perf_bubble;
`endif

`ifndef SYNTHESIS
    // A response landing while the skid is still occupied would be lost.
    always_ff @(posedge clk) begin
        assert (!(rst_n && w_rsp && r_skid_vld));
    end
`endif

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Purpose : randomized + scripted bench for fetch_decode_ctrl against a stream-level reference model.
// Latency : one tick() per clock; inputs driven just after the rising edge, outputs sampled away from it.
// Backpres: bench memory grants at will and returns responses after a configurable latency.
module tb_fetch_decode_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          NOBS   = 4096;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_d_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic        valid_d_o;

    fetch_decode_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_d_i     (stall_d_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_d_o     (instr_d_o),
        .pc_d_o        (pc_d_o),
        .pc_plus4_d_o  (pc_plus4_d_o),
        .valid_d_o     (valid_d_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents: every word is a fixed scramble of its address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Bench memory
    logic        pend_vld = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic        gnt_rand = 1'b0;
    logic        gnt_block = 1'b0;

    // Reference model: fetch stream and decode stream are both "sequential from last target".
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_dec_pc = RST_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic        prev_req_wait = 1'b0;
    logic        last_fire = 1'b0;
    int          loads = 0;
    int          gcyc = 0;

    logic        obs_req  [NOBS];
    logic [31:0] obs_addr [NOBS];
    logic        obs_vld  [NOBS];
    logic [31:0] obs_pc   [NOBS];
    logic [31:0] obs_pc4  [NOBS];

    task automatic tick();
        logic        s_req, s_fire, s_rv, s_stall, s_redir, s_rst;
        logic [31:0] s_addr, s_rpc;
        imem_rvalid_i = rst_n && pend_vld && (pend_cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? instr_of(pend_addr) : 32'hDEAD_BEEF;
        #1;
        imem_gnt_i = imem_req_o && !gnt_block && (!gnt_rand || ($urandom_range(2, 0) != 0));
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_fire  = s_req && imem_gnt_i;
        s_rv    = imem_rvalid_i;
        s_stall = stall_d_i;
        s_redir = redirect_i;
        s_rpc   = redirect_pc_i;
        s_rst   = !rst_n;
        if (rst_n) begin
            if (s_redir) chk("req_on_redirect", s_req, 0);
            if (s_stall && s_rv) chk("req_on_stall_rsp", s_req, 0);
            if (pend_vld && !s_rv) chk("req_outstanding", s_req, 0);
            if (s_req) chk("fetch_addr", s_addr, exp_fetch);
            if (prev_req_wait && !s_redir) chk("req_sticky", s_req, 1);
        end
        if (gcyc < NOBS) begin
            obs_req[gcyc]  = s_req;
            obs_addr[gcyc] = s_addr;
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            chk("rst_valid", valid_d_o, 0);
            chk("rst_instr", instr_d_o, 0);
            chk("rst_pc", pc_d_o, 0);
            chk("rst_pc4", pc_plus4_d_o, 0);
            chk("rst_req", imem_req_o, 0);
            pend_vld      = 1'b0;
            exp_fetch     = RST_PC;
            exp_dec_pc    = RST_PC;
            m_valid       = 1'b0;
            prev_req_wait = 1'b0;
            last_fire     = 1'b0;
        end else begin
            if (s_rv) pend_vld = 1'b0;
            else if (pend_vld && pend_cnt > 0) pend_cnt--;
            if (s_fire) begin
                pend_vld  = 1'b1;
                pend_addr = s_addr;
                pend_cnt  = $urandom_range(lat_max, lat_min);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (s_redir) exp_fetch = s_rpc;
            prev_req_wait = s_req && !s_fire;
            last_fire     = s_fire;

            if (s_redir) begin
                chk("flush_valid", valid_d_o, 0);
                m_valid    = 1'b0;
                exp_dec_pc = s_rpc;
            end else if (s_stall) begin
                chk("hold_valid", valid_d_o, m_valid);
                if (m_valid) begin
                    chk("hold_pc", pc_d_o, m_pc);
                    chk("hold_instr", instr_d_o, m_instr);
                end
            end else if (valid_d_o) begin
                chk("dec_pc", pc_d_o, exp_dec_pc);
                chk("dec_instr", instr_d_o, instr_of(exp_dec_pc));
                chk("dec_pc4", pc_plus4_d_o, exp_dec_pc + 32'd4);
                m_valid    = 1'b1;
                m_pc       = exp_dec_pc;
                m_instr    = instr_of(exp_dec_pc);
                exp_dec_pc = exp_dec_pc + 32'd4;
                loads++;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (gcyc < NOBS) begin
            obs_vld[gcyc] = valid_d_o;
            obs_pc[gcyc]  = pc_d_o;
            obs_pc4[gcyc] = pc_plus4_d_o;
        end
        gcyc++;
    endtask

    task automatic run_until_fire(input int budget);
        last_fire = 1'b0;
        for (int k = 0; k < budget && !last_fire; k++) tick();
        chk("fire_timeout", last_fire, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  g0, gr, gd, ge, gb, loads0;
        logic found;
        rst_n = 1'b0; stall_d_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

        // Reset, back-to-back fetch, then a 3-cycle stall while 0x8 returns.
        repeat (3) tick();
        rst_n = 1'b1;
        g0 = gcyc;
        for (int k = 0; k < 10; k++) begin
            stall_d_i = (k >= 4 && k <= 6);
            tick();
        end
        stall_d_i = 1'b0;
        chk("a_idle_req", obs_req[g0], 0);
        chk("a_req1", obs_req[g0+1], 1);
        chk("a_addr1", obs_addr[g0+1], 32'h0);
        chk("a_addr2", obs_addr[g0+2], 32'h4);
        chk("a_addr3", obs_addr[g0+3], 32'h8);
        chk("a_vld0", obs_vld[g0+2], 1);
        chk("a_pc0", obs_pc[g0+2], 32'h0);
        chk("a_pc4_0", obs_pc4[g0+2], 32'h4);
        chk("a_pc1", obs_pc[g0+3], 32'h4);
        chk("a_pc4_1", obs_pc4[g0+3], 32'h8);
        for (int k = 4; k <= 6; k++) begin
            chk("b_stall_req", obs_req[g0+k], 0);
            chk("b_stall_pc", obs_pc[g0+k], 32'h4);
        end
        chk("b_skid_vld", obs_vld[g0+7], 1);
        chk("b_skid_pc", obs_pc[g0+7], 32'h8);
        chk("b_skid_pc4", obs_pc4[g0+7], 32'hC);
        chk("b_next_addr", obs_addr[g0+8], 32'hC);

        // Redirect while waiting on a slow response.
        lat_min = 2; lat_max = 2;
        run_until_fire(20);
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        gr = gcyc;
        tick();
        redirect_i = 1'b0;
        chk("c_flush", obs_vld[gr], 0);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (obs_req[gcyc-1]) begin
                found = 1'b1;
                chk("c_addr", obs_addr[gcyc-1], 32'h100);
            end
        end
        chk("c_req_seen", found, 1);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (obs_vld[gcyc-1]) begin
                found = 1'b1;
                chk("c_pc", obs_pc[gcyc-1], 32'h100);
            end
        end
        chk("c_vld_seen", found, 1);

        // Redirect and stall together while the skid is full.
        lat_min = 0; lat_max = 0;
        run_until_fire(20);
        stall_d_i = 1'b1;
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        gd = gcyc;
        tick();
        stall_d_i = 1'b0; redirect_i = 1'b0;
        chk("d_flush", obs_vld[gd], 0);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (obs_vld[gcyc-1]) begin
                found = 1'b1;
                chk("d_pc", obs_pc[gcyc-1], 32'h200);
            end
        end
        chk("d_vld_seen", found, 1);

        // Reset in the middle of WAIT, then restart with a delayed grant on 0x4.
        lat_min = 5; lat_max = 5;
        run_until_fire(20);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        lat_min = 0; lat_max = 0;
        ge = gcyc;
        run_until_fire(20);
        chk("f_restart_addr", obs_addr[gcyc-1], RST_PC);
        chk("f_first_req_cyc", gcyc - 1 - ge, 1);
        gnt_block = 1'b1;
        gb = gcyc;
        repeat (4) tick();
        gnt_block = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("e_req_held", obs_req[gb+k], 1);
            chk("e_addr_held", obs_addr[gb+k], 32'h4);
        end
        chk("e_first_vld", obs_vld[gb], 1);
        for (int k = 1; k < 4; k++) chk("e_bubble", obs_vld[gb+k], 0);
        repeat (6) tick();

        // Random traffic.
        gnt_rand = 1'b1; lat_min = 0; lat_max = 3;
        loads0 = loads;
        for (int k = 0; k < 2500; k++) begin
            stall_d_i  = ($urandom_range(4, 0) == 0);
            redirect_i = ($urandom_range(19, 0) == 0);
            if ($urandom_range(7, 0) == 0)
                redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0)) * 32'd4;
            else
                redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        stall_d_i = 1'b0; redirect_i = 1'b0;
        repeat (10) tick();
        chk("g_progress", (loads - loads0) > 300, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
